// File: rtl/expr_check.sv
// expr_check: streaming syntax checker for simple arithmetic expressions.
// One ASCII character is consumed per clock on which in_valid is high.
// out reports whether the characters so far form a complete expression,
// and err latches (until clr) as soon as the stream becomes unparseable.
module expr_check #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 3,
  parameter int EN_PAREN   = 1,
  parameter int EN_SUBDIV  = 1,
  parameter int EN_SPACE   = 1,
  parameter int CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [7:0]                     in,
  output logic                           out,
  output logic                           err,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic [CNT_W-1:0]               op_cnt
);

  localparam int DEP_W = $clog2(MAX_DEPTH + 1);
  localparam int DIG_W = $clog2(MAX_DIGITS + 1);

  localparam logic [DEP_W-1:0] DEP_MAX  = DEP_W'(MAX_DEPTH);
  localparam logic [DEP_W-1:0] DEP_ONE  = DEP_W'(1);
  localparam logic [DEP_W-1:0] DEP_ZERO = DEP_W'(0);
  localparam logic [DIG_W-1:0] DIG_MAX  = DIG_W'(MAX_DIGITS);
  localparam logic [DIG_W-1:0] DIG_ONE  = DIG_W'(1);
  localparam logic [DIG_W-1:0] DIG_ZERO = DIG_W'(0);
  localparam logic [CNT_W-1:0] OPS_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] OPS_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] OPS_SAT  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_EXPECT = 2'd0,  // an operand must come next
    S_NUM    = 2'd1,  // inside a number
    S_AFTER  = 2'd2,  // operand finished by space or ')'
    S_ERR    = 2'd3   // stream rejected, absorbing
  } state_e;

  state_e           state_q, state_d;
  logic [DEP_W-1:0] depth_q, depth_d;
  logic [DIG_W-1:0] dcnt_q,  dcnt_d;
  logic [CNT_W-1:0] ops_q,   ops_d;
  logic             out_q,   out_d;
  logic             err_q,   err_d;

  // Character classes; disabled characters simply never match a legal class.
  logic is_digit_s, is_lp_s, is_rp_s, is_sp_s, is_op_s;
  logic [CNT_W-1:0] ops_inc_s;

  // Classify the incoming character and precompute the saturating op count.
  always_comb begin
    is_digit_s = (in >= 8'h30) && (in <= 8'h39);
    is_lp_s    = (EN_PAREN != 0) && (in == 8'h28);
    is_rp_s    = (EN_PAREN != 0) && (in == 8'h29);
    is_sp_s    = (EN_SPACE != 0) && (in == 8'h20);
    is_op_s    = (in == 8'h2B) || (in == 8'h2A) ||
                 ((EN_SUBDIV != 0) && ((in == 8'h2D) || (in == 8'h2F)));
    if (ops_q == OPS_SAT) begin
      ops_inc_s = ops_q;
    end else begin
      ops_inc_s = ops_q + OPS_ONE;
    end
  end

  // Next-state logic of the parser; every path out of NUM clears the digit count.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    dcnt_d  = dcnt_q;
    ops_d   = ops_q;
    if (in_valid) begin
      case (state_q)
        S_EXPECT: begin
          if (is_digit_s) begin
            state_d = S_NUM;
            dcnt_d  = DIG_ONE;
          end else if (is_lp_s) begin
            if (depth_q < DEP_MAX) begin
              depth_d = depth_q + DEP_ONE;
            end else begin
              state_d = S_ERR;
            end
          end else if (is_sp_s) begin
            state_d = S_EXPECT;
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_digit_s) begin
            if (dcnt_q < DIG_MAX) begin
              dcnt_d = dcnt_q + DIG_ONE;
            end else begin
              state_d = S_ERR;
              dcnt_d  = DIG_ZERO;
            end
          end else if (is_op_s) begin
            state_d = S_EXPECT;
            dcnt_d  = DIG_ZERO;
            ops_d   = ops_inc_s;
          end else if (is_rp_s) begin
            dcnt_d = DIG_ZERO;
            if (depth_q != DEP_ZERO) begin
              state_d = S_AFTER;
              depth_d = depth_q - DEP_ONE;
            end else begin
              state_d = S_ERR;
            end
          end else if (is_sp_s) begin
            state_d = S_AFTER;
            dcnt_d  = DIG_ZERO;
          end else begin
            state_d = S_ERR;
            dcnt_d  = DIG_ZERO;
          end
        end
        S_AFTER: begin
          if (is_op_s) begin
            state_d = S_EXPECT;
            ops_d   = ops_inc_s;
          end else if (is_rp_s) begin
            if (depth_q != DEP_ZERO) begin
              depth_d = depth_q - DEP_ONE;
            end else begin
              state_d = S_ERR;
            end
          end else if (is_sp_s) begin
            state_d = S_AFTER;
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_ERR;
          dcnt_d  = DIG_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    out_d = ((state_d == S_NUM) || (state_d == S_AFTER)) && (depth_d == DEP_ZERO);
    err_d = (state_d == S_ERR);
  end

  // Parser state and registered status outputs; clr clears everything at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_EXPECT;
      depth_q <= DEP_ZERO;
      dcnt_q  <= DIG_ZERO;
      ops_q   <= OPS_ZERO;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      dcnt_q  <= dcnt_d;
      ops_q   <= ops_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign out    = out_q;
  assign err    = err_q;
  assign depth  = depth_q;
  assign op_cnt = ops_q;

endmodule

// File: tb/tb_expr_check.sv
// Directed bench for expr_check: instance A uses default parameters,
// instance B disables parens, '-', '/', and space, with tiny limits.
module tb_expr_check;

  logic       clk;
  logic       clr_a, v_a, clr_b, v_b;
  logic [7:0] in_a, in_b;
  logic       out_a, err_a, out_b, err_b;
  logic [1:0] depth_a;
  logic       depth_b;
  logic [7:0] ops_a;
  logic [1:0] ops_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected-value tables for the current stream; an empty queue means "not checked".
  int q_out[$];
  int q_err[$];
  int q_dep[$];
  int q_ops[$];

  expr_check u_a (
    .clk(clk), .clr(clr_a), .in_valid(v_a), .in(in_a),
    .out(out_a), .err(err_a), .depth(depth_a), .op_cnt(ops_a)
  );

  expr_check #(
    .MAX_DIGITS(2), .MAX_DEPTH(1), .EN_PAREN(0), .EN_SUBDIV(0),
    .EN_SPACE(0), .CNT_W(2)
  ) u_b (
    .clk(clk), .clr(clr_b), .in_valid(v_b), .in(in_b),
    .out(out_b), .err(err_b), .depth(depth_b), .op_cnt(ops_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare all four outputs of one instance.
  task automatic chk_all(input bit sel, input string tag,
                         input int eo, input int ee, input int ed, input int eops);
    if (sel) begin
      chk({tag, ".out"}, int'(out_b), eo);
      chk({tag, ".err"}, int'(err_b), ee);
      chk({tag, ".depth"}, int'(depth_b), ed);
      chk({tag, ".op_cnt"}, int'(ops_b), eops);
    end else begin
      chk({tag, ".out"}, int'(out_a), eo);
      chk({tag, ".err"}, int'(err_a), ee);
      chk({tag, ".depth"}, int'(depth_a), ed);
      chk({tag, ".op_cnt"}, int'(ops_a), eops);
    end
  endtask

  // Present one character for exactly one posedge; returns 1 time unit after it.
  task automatic send(input bit sel, input byte c);
    if (sel) begin in_b = c; v_b = 1'b1; end
    else begin in_a = c; v_a = 1'b1; end
    @(posedge clk);
    #1;
    v_a = 1'b0;
    v_b = 1'b0;
  endtask

  // Feed a string and check every output that has an expected-value table.
  task automatic run(input bit sel, input string tag, input string s);
    for (int i = 0; i < s.len(); i++) begin
      send(sel, s[i]);
      if (q_out.size() > i) chk($sformatf("%s[%0d].out", tag, i), sel ? int'(out_b) : int'(out_a), q_out[i]);
      if (q_err.size() > i) chk($sformatf("%s[%0d].err", tag, i), sel ? int'(err_b) : int'(err_a), q_err[i]);
      if (q_dep.size() > i) chk($sformatf("%s[%0d].depth", tag, i), sel ? int'(depth_b) : int'(depth_a), q_dep[i]);
      if (q_ops.size() > i) chk($sformatf("%s[%0d].op_cnt", tag, i), sel ? int'(ops_b) : int'(ops_a), q_ops[i]);
    end
    q_out.delete(); q_err.delete(); q_dep.delete(); q_ops.delete();
  endtask

  // Asynchronous clear pulse placed between clock edges.
  task automatic pulse_clr(input bit sel, input string tag);
    if (sel) clr_b = 1'b1; else clr_a = 1'b1;
    #2;
    chk_all(sel, tag, 0, 0, 0, 0);
    clr_a = 1'b0;
    clr_b = 1'b0;
    #1;
  endtask

  // Hold in_valid low for n clocks.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clr_a = 1'b1; clr_b = 1'b1;
    v_a = 1'b0; v_b = 1'b0;
    in_a = 8'h00; in_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all(0, "reset_a", 0, 0, 0, 0);
    chk_all(1, "reset_b", 0, 0, 0, 0);
    clr_a = 1'b0; clr_b = 1'b0;
    #1;

    // "12+3*45" with an idle gap after '+'
    q_out = '{1, 1, 0}; q_err = '{0, 0, 0}; q_ops = '{0, 0, 1};
    run(0, "s1a", "12+");
    idle(3);
    chk_all(0, "gap_expect", 0, 0, 0, 1);
    q_out = '{1, 0, 1, 1}; q_err = '{0, 0, 0, 0}; q_ops = '{1, 2, 2, 2};
    run(0, "s1b", "3*45");
    pulse_clr(0, "clr_after_s1");

    // "(1+(2))*3"
    q_out = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    q_dep = '{1, 1, 1, 2, 2, 1, 0, 0, 0};
    q_err = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    q_ops = '{0, 0, 1, 1, 1, 1, 1, 2, 2};
    run(0, "s2", "(1+(2))*3");
    pulse_clr(0, "clr_after_s2");

    // "12345" overflows four digits; "+1" afterwards cannot recover
    q_out = '{1, 1, 1, 1, 0}; q_err = '{0, 0, 0, 0, 1};
    run(0, "s3", "12345");
    q_out = '{0, 0}; q_err = '{1, 1}; q_ops = '{0, 0}; q_dep = '{0, 0};
    run(0, "s3err", "+1");
    idle(2);
    chk_all(0, "gap_err", 0, 1, 0, 0);
    pulse_clr(0, "clr_in_err");
    q_out = '{1}; q_err = '{0};
    run(0, "restart", "7");
    pulse_clr(0, "clr_after_restart");

    // "1 2": digit after a space-terminated number
    q_out = '{1, 1, 0}; q_err = '{0, 0, 1};
    run(0, "s4", "1 2");
    pulse_clr(0, "clr_after_s4");

    // "((((1": fourth '(' exceeds MAX_DEPTH=3, depth freezes
    q_dep = '{1, 2, 3, 3, 3}; q_err = '{0, 0, 0, 1, 1};
    run(0, "s5", "((((1");
    pulse_clr(0, "clr_after_s5");

    // ')' at depth 0
    q_err = '{1}; q_dep = '{0};
    run(0, "rp0", ")");
    pulse_clr(0, "clr_after_rp0");

    // digit after ')'
    q_out = '{0, 0, 1, 0}; q_err = '{0, 0, 0, 1};
    run(0, "s6", "(1)2");
    pulse_clr(0, "clr_after_s6");

    // '-' and '/' are legal by default
    q_out = '{1, 0, 1, 0, 1}; q_ops = '{0, 1, 1, 2, 2}; q_err = '{0, 0, 0, 0, 0};
    run(0, "s7", "8/2-1");
    pulse_clr(0, "clr_after_s7");

    // spaces around an operator
    q_out = '{1, 1, 0, 1}; q_ops = '{0, 0, 1, 1}; q_err = '{0, 0, 0, 0};
    run(0, "s8", "1 +2");
    pulse_clr(0, "clr_after_s8");

    // clr wins over a valid character on the same edge
    clr_a = 1'b1; in_a = 8'h35; v_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0; v_a = 1'b0;
    chk_all(0, "clr_prio", 0, 0, 0, 0);
    q_err = '{1};
    run(0, "clr_prio_op", "+");
    pulse_clr(0, "clr_after_prio");

    // Instance B: op_cnt saturates at 3 with CNT_W=2
    q_out = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    q_ops = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3};
    q_err = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run(1, "b_sat", "1+1+1+1+1+1");
    pulse_clr(1, "b_clr1");

    // MAX_DIGITS=2
    q_out = '{1, 1, 0}; q_err = '{0, 0, 1};
    run(1, "b_dig", "123");
    pulse_clr(1, "b_clr2");

    // '-' disabled, with an idle gap after the error
    q_out = '{1, 0}; q_err = '{0, 1};
    run(1, "b_sub", "7-");
    idle(2);
    chk_all(1, "b_gap", 0, 1, 0, 0);
    q_out = '{0}; q_err = '{1};
    run(1, "b_sub2", "2");
    pulse_clr(1, "b_clr3");

    // space, '(' and '/' disabled
    q_out = '{1, 0}; q_err = '{0, 1};
    run(1, "b_sp", "1 ");
    pulse_clr(1, "b_clr4");
    q_err = '{1};
    run(1, "b_lp", "(");
    pulse_clr(1, "b_clr5");
    q_out = '{1, 0}; q_err = '{0, 1};
    run(1, "b_div", "4/");
    pulse_clr(1, "b_clr6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
